pipeline_hazard_ctrl: RTL

//  Hazard/sequencing controller for the 5-stage pipeline (F/D/E/M/W).
//  - Generates per-stage stall and flush controls for the pipeline registers.
//  - Generates E-stage operand forwarding selects.
//  - Sequences a multi-cycle data-memory wait, with a watchdog timeout.
//  - Keeps performance counters for stall and flush cycles.

---
 rtl/riscv_pipe_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 32 +++
 rtl/pipeline_hazard_ctrl_fwd.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//  hz_state_t : hazard FSM states (RUN, MEM_WAIT)
//  FWD_*      : E-stage operand forwarding select encodings
//  fwd_sel()  : forwarding select for one E-stage source register
package riscv_pipe_pkg;

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M-stage result is younger than W-stage, so it is checked first.
  // x0 is hardwired to zero and is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] rd_m, input logic rw_m,
                                         input logic [4:0] rd_w, input logic rw_w);
    if (rw_m && rd_m != 5'd0 && rd_m == rs)      return FWD_M;
    else if (rw_w && rd_w != 5'd0 && rd_w == rs) return FWD_W;
    else                                         return FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
//  master : pipeline datapath side (drives register ids / stage status,
//           receives stall, flush, forward, timeout and counters)
//  slave  : hazard controller side
interface pipeline_hazard_ctrl_if #(parameter int CNT_WIDTH = 32);
  logic [4:0]           rs1_D, rs2_D;
  logic [4:0]           rs1_E, rs2_E, rd_E;
  logic                 MemRead_E, PCSrc_E;
  logic [4:0]           rd_M;
  logic                 RegWrite_M, dmem_req_M, dmem_ready;
  logic [4:0]           rd_W;
  logic                 RegWrite_W;
  logic                 Stall_F, Stall_D, Stall_E, Stall_M;
  logic                 Flush_D, Flush_E;
  logic [1:0]           ForwardA_E, ForwardB_E;
  logic                 mem_timeout;
  logic [CNT_WIDTH-1:0] stall_cycles, flush_events;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, MemRead_E, PCSrc_E,
           rd_M, RegWrite_M, dmem_req_M, dmem_ready, rd_W, RegWrite_W,
    input  Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
           ForwardA_E, ForwardB_E, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, MemRead_E, PCSrc_E,
           rd_M, RegWrite_M, dmem_req_M, dmem_ready, rd_W, RegWrite_W,
    output Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E,
           ForwardA_E, ForwardB_E, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// forwarding_unit: combinational E-stage operand forwarding selects.
//  rs1_E/rs2_E          : E-stage source registers
//  rd_M/RegWrite_M      : M-stage writer
//  rd_W/RegWrite_W      : W-stage writer
//  fwd_a/fwd_b          : FWD_RF / FWD_M / FWD_W per operand
module forwarding_unit
  import riscv_pipe_pkg::*;
(
  input  logic [4:0] rs1_E,
  input  logic [4:0] rs2_E,
  input  logic [4:0] rd_M,
  input  logic       RegWrite_M,
  input  logic [4:0] rd_W,
  input  logic       RegWrite_W,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);
  assign fwd_a = fwd_sel(rs1_E, rd_M, RegWrite_M, rd_W, RegWrite_W);
  assign fwd_b = fwd_sel(rs2_E, rd_M, RegWrite_M, rd_W, RegWrite_W);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control for the 5-stage pipe,
// data-memory wait sequencing with watchdog, and perf counters.
//  clk, rst : clock (rising edge), asynchronous active-high reset
//  hz       : pipeline_hazard_ctrl_if.slave (stage ids in; controls,
//             mem_timeout pulse, stall_cycles, flush_events out)
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int TIMEOUT   = 256,
  parameter int CNT_WIDTH = 32
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int              WCW      = $clog2(TIMEOUT);
  localparam logic [WCW-1:0]  WAIT_MAX = WCW'(TIMEOUT - 1);

  hz_state_t            state, state_nxt;
  logic [WCW-1:0]       wait_cnt, wait_cnt_nxt;
  logic                 pend_flush, pend_nxt;
  logic                 mem_timeout, timeout_nxt;
  logic [CNT_WIDTH-1:0] stall_cnt, flush_cnt;

  logic                 mem_stall, load_use, br_flush, lu_stall;
  logic                 stall_f, stall_e, flush_d, flush_e;
  logic [1:0]           fwd_a, fwd_b;

  // Memory wait FSM. The release cycle (ready or watchdog) is not stalled,
  // so the M instruction advances in the same cycle the access completes.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_nxt  = 1'b0;
    mem_stall    = 1'b0;
    case (state)
      RUN: begin
        if (hz.dmem_req_M && !hz.dmem_ready) begin
          mem_stall    = 1'b1;
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WCW'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ready) begin
          state_nxt = RUN;
        end else if (wait_cnt == WAIT_MAX) begin
          // abort: behave as if ready; wait_cnt holds (no wrap)
          state_nxt   = RUN;
          timeout_nxt = 1'b1;
        end else begin
          mem_stall    = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // A branch seen while stalled is remembered so the flush lands exactly
  // once, on the first cycle the pipe moves again.
  always_comb begin
    load_use = hz.MemRead_E && (hz.rd_E != 5'd0) &&
               ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
    br_flush = !mem_stall && (hz.PCSrc_E || pend_flush);
    // the D instruction is discarded on a branch, so no bubble is needed
    lu_stall = !mem_stall && load_use && !br_flush;
    pend_nxt = mem_stall && (pend_flush || hz.PCSrc_E);

    stall_f  = !rst && (mem_stall || lu_stall);
    stall_e  = !rst && mem_stall;
    flush_d  = !rst && br_flush;
    flush_e  = !rst && (br_flush || lu_stall);
  end

  forwarding_unit u_fwd (
    .rs1_E      (hz.rs1_E),
    .rs2_E      (hz.rs2_E),
    .rd_M       (hz.rd_M),
    .RegWrite_M (hz.RegWrite_M),
    .rd_W       (hz.rd_W),
    .RegWrite_W (hz.RegWrite_W),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      pend_flush  <= 1'b0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      pend_flush  <= pend_nxt;
      mem_timeout <= timeout_nxt;
      if (stall_f) stall_cnt <= stall_cnt + 1'b1;
      if (flush_e) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign hz.Stall_F      = stall_f;
  assign hz.Stall_D      = stall_f;
  assign hz.Stall_E      = stall_e;
  assign hz.Stall_M      = stall_e;
  assign hz.Flush_D      = flush_d;
  assign hz.Flush_E      = flush_e;
  assign hz.ForwardA_E   = rst ? FWD_RF : fwd_a;
  assign hz.ForwardB_E   = rst ? FWD_RF : fwd_b;
  assign hz.mem_timeout  = mem_timeout;
  assign hz.stall_cycles = stall_cnt;
  assign hz.flush_events = flush_cnt;

endmodule
